// File: rtl/prog_lut.sv
// prog_lut: registered N-input truth-table evaluator with valid/ready streams and a serial table-load port.
// Define LUT_CFG_CHECK_EN to require an even-parity beat after each frame; failed frames leave the table intact.
module prog_lut #(
    parameter int                  N    = 4,
    parameter logic [(2**N)-1:0]   INIT = 16'hD073
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         f,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_busy,
    output logic         cfg_done,
    output logic         cfg_err
);
    localparam int         TBL  = 2**N;
    localparam logic [N:0] LAST = (N+1)'(TBL-1);

`ifdef LUT_CFG_CHECK_EN
    typedef enum logic [1:0] {RUN, LOAD, CHK} state_t;
`else
    typedef enum logic [1:0] {RUN, LOAD} state_t;
`endif

    state_t           state_q, state_d;
    logic [TBL-1:0]   t_q, t_d;
    logic [TBL-1:0]   s_q, s_d;
    logic [N:0]       cnt_q, cnt_d;
    logic             f_q, f_d;
    logic             out_valid_q, out_valid_d;
    logic             cfg_done_q, cfg_done_d;
`ifdef LUT_CFG_CHECK_EN
    logic             cfg_err_q, cfg_err_d;
`endif

    // New operands are only taken in RUN, and only when the output slot is free or draining.
    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign cfg_busy  = (state_q != RUN);
    assign cfg_done  = cfg_done_q;
`ifdef LUT_CFG_CHECK_EN
    assign cfg_err   = cfg_err_q;
`else
    assign cfg_err   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        f_d         = f_q;
        out_valid_d = out_valid_q;
        cfg_done_d  = 1'b0;
`ifdef LUT_CFG_CHECK_EN
        cfg_err_d   = 1'b0;
`endif

        if (in_valid && in_ready) begin
            f_d         = t_q[x];
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (cfg_valid) begin
                    s_d[0]  = cfg_bit;
                    cnt_d   = (N+1)'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cfg_valid) begin
                    s_d[cnt_q[N-1:0]] = cfg_bit;
                    cnt_d             = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
`ifdef LUT_CFG_CHECK_EN
                        state_d = CHK;
`else
                        t_d        = s_d;
                        cfg_done_d = 1'b1;
                        state_d    = RUN;
`endif
                    end
                end
            end
`ifdef LUT_CFG_CHECK_EN
            CHK: begin
                // Parity beat makes the total number of ones in the frame even.
                if (cfg_valid) begin
                    if (cfg_bit == ^s_q) begin
                        t_d        = s_q;
                        cfg_done_d = 1'b1;
                    end else begin
                        cfg_err_d  = 1'b1;
                    end
                    state_d = RUN;
                end
            end
`endif
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            t_q         <= INIT;
            s_q         <= '0;
            cnt_q       <= '0;
            f_q         <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_done_q  <= 1'b0;
`ifdef LUT_CFG_CHECK_EN
            cfg_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
            cfg_done_q  <= cfg_done_d;
`ifdef LUT_CFG_CHECK_EN
            cfg_err_q   <= cfg_err_d;
`endif
        end
    end

endmodule

// File: doc/prog_lut.md
# prog_lut

Programmable, registered N-input Boolean function evaluator with a valid/ready input stream, a valid/ready output stream and a serial truth-table load port. It replaces fixed hard-coded truth-table blocks in the logic-function library: the reset-time function comes from a parameter, and the function can be reprogrammed at run time without resynthesis. It sits between a stimulus/operand source and any downstream consumer that applies backpressure.

## Interface
- N, 4: number of function inputs (1..8); the table holds 2**N entries.
- INIT, 16'hD073: reset truth table, 2**N bits wide; bit i is f(x=i).
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  x is valid
- in_ready  out  1  block accepts x this cycle
- x  in  N  function input
- out_valid  out  1  f is valid
- out_ready  in  1  consumer accepts f this cycle
- f  out  1  registered function result
- cfg_valid  in  1  cfg_bit is valid (no ready; always sampled)
- cfg_bit  in  1  next truth-table bit, entry 0 first
- cfg_busy  out  1  a load frame is in progress
- cfg_done  out  1  one-cycle pulse: new table committed
- cfg_err  out  1  one-cycle pulse: frame rejected (only with LUT_CFG_CHECK_EN)

One clock; reset is synchronous and active-high.

## Operation
- Storage: active table T (2**N bits) and shadow S (2**N bits); bit counter cnt (N+1 bits).
- States: RUN, LOAD, CHK (CHK exists only with macro).
- RUN: in_ready = (!out_valid | out_ready). Accept when in_valid & in_ready: f <= T[x], out_valid <= 1. If out_ready & out_valid and no accept: out_valid <= 0. f holds stable while out_valid & !out_ready.
- RUN + cfg_valid: S[0] <= cfg_bit, cnt <= 1, go LOAD. An input accepted in the same cycle uses the old T.
- LOAD: in_ready = 0; output stage still drains. Each cfg_valid writes S[cnt], cnt++. Idle cycles (cfg_valid=0) allowed, no timeout. When bit 2**N-1 is written: without macro T <= S, cfg_done pulse next cycle, go RUN; with macro go CHK.
- CHK: next cfg_valid bit is the even-parity bit over S. Match: T <= S, cfg_done. Mismatch: T unchanged, cfg_err. Either way go RUN.
- cfg_busy = (state != RUN).
- Reset (including mid-load): T <= INIT, S <= 0, cnt <= 0, state RUN, partial frame discarded.

## Timing
- Reset values: in_ready 1 (after reset cycle), out_valid 0, f 0, cfg_busy 0, cfg_done 0, cfg_err 0.
- Latency x->f: 1 cycle (registered); throughput 1 result/cycle with out_ready held high.
- Load frame: 2**N cfg_valid beats (+1 parity beat with macro); cfg_done/cfg_err asserted the cycle after the final beat; first evaluation using new T accepted the same cycle in_ready returns to 1.
- Backpressure: result never dropped or overwritten while out_valid & !out_ready.
- cfg_valid while busy is always a frame bit; no restart mid-frame except via reset.

## Configuration
- LUT_CFG_CHECK_EN defined: CHK state, parity beat and cfg_err present; corrupted frames leave T intact.
- Undefined: no CHK state, frame is exactly 2**N beats, cfg_err tied 0.

## Test plan
- Reset, N=4 default INIT; stream x=0..15 with out_ready=1 -> f sequence 1,1,0,0,1,1,1,0,0,0,0,0,1,0,1,1, each one cycle after accept.
- Hold out_ready=0 after x=2 accepted -> out_valid=1, f=0 held, in_ready=0 until out_ready=1; x=3 then accepted, f=0.
- Load 16 ones (with macro, parity bit 0) -> cfg_done pulses once, cfg_busy low; x=2 -> f=1, x=13 -> f=1.
- Same-cycle: accept x=12 while first cfg beat arrives -> f=1 from old T; in_ready=0 for remainder of frame.
- Reset after 7 load beats -> cfg_busy=0, x=2 -> f=0 (INIT restored), next frame starts at entry 0.
- Macro on: load 16 ones with parity bit 1 -> cfg_err pulse, no cfg_done, x=2 -> f=0.
